// File: rtl/inst_loader.sv
`timescale 1ns/1ps
// inst_loader: receives a little-endian byte stream (word-count header, then words), writes the words
// into instruction memory, and holds the core in reset until the whole program is written.
module inst_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             inst_store,
    output logic [WIDTH-1:0] inst_addr,
    output logic [WIDTH-1:0] inst_in,
    output logic             core_rst,
    output logic             load_done,
    output logic             load_err
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, ERR} state_t;

    state_t         r_state, w_next;
    logic [1:0]     r_byte_cnt;
    logic [CW-1:0]  r_word_cnt, r_n;
    logic [23:0]    r_asm;
    logic           r_store;
    logic [WIDTH-1:0] r_addr, r_inst;
    logic [31:0]    w_word;
    logic           w_accept, w_last_byte, w_hdr_ok, w_last_word, w_restart;

    // the current byte completes the word on top of the three already shifted in
    assign w_word      = {byte_data, r_asm};
    assign w_accept    = byte_valid && byte_ready;
    assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
    assign w_hdr_ok    = (w_word != 32'd0) && (w_word <= 32'(DEPTH));
    assign w_last_word = (r_word_cnt == r_n - CW'(1));
    assign w_restart   = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));

    assign byte_ready = (r_state == HDR) || (r_state == LOAD);
    assign core_rst   = (r_state != DONE);
    assign load_done  = (r_state == DONE);
    assign load_err   = (r_state == ERR);
    assign inst_store = r_store;
    assign inst_addr  = r_addr;
    assign inst_in    = r_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = start ? HDR : IDLE;
            HDR:       w_next = w_last_byte ? (w_hdr_ok ? LOAD : ERR) : HDR;
            LOAD:      w_next = (w_last_byte && w_last_word) ? DONE : LOAD;
            DONE, ERR: w_next = start ? HDR : r_state;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_n        <= '0;
            r_asm      <= '0;
            r_store    <= 1'b0;
            r_addr     <= '0;
            r_inst     <= '0;
        end else begin
            r_store <= 1'b0;
            if (w_restart) begin
                r_byte_cnt <= '0;
                r_word_cnt <= '0;
            end else if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_asm      <= w_word[31:8];
                if (w_last_byte && r_state == HDR) begin
                    r_n        <= w_word[CW-1:0];
                    r_word_cnt <= '0;
                end
                if (w_last_byte && r_state == LOAD) begin
                    r_store    <= 1'b1;
                    r_inst     <= WIDTH'(w_word);
                    r_addr     <= WIDTH'({r_word_cnt, 2'b00});
                    r_word_cnt <= r_word_cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
`timescale 1ns/1ps
// tb_inst_loader: scoreboard bench; expected writes are queued as stimulus is driven and
// popped by a monitor whenever the loader pulses inst_store.
module tb_inst_loader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 256;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             byte_valid = 1'b0;
    logic [7:0]       byte_data = 8'h00;
    logic             byte_ready, inst_store, core_rst, load_done, load_err;
    logic [WIDTH-1:0] inst_addr, inst_in;

    typedef struct {
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
        bit               last;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_e;
    logic [31:0] prog[$];
    int          checks = 0;
    int          failures = 0;

    inst_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .inst_store(inst_store), .inst_addr(inst_addr), .inst_in(inst_in),
        .core_rst(core_rst), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && inst_store) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_store got addr=%h data=%h expected no write", inst_addr, inst_in);
            end else begin
                m_e = sb.pop_front();
                if (inst_addr !== m_e.addr || inst_in !== m_e.data) begin
                    failures++;
                    $display("FAIL store_word got addr=%h data=%h expected addr=%h data=%h",
                             inst_addr, inst_in, m_e.addr, m_e.data);
                end
                checks++;
                if ({load_done, core_rst} !== (m_e.last ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL store_status got load_done=%b core_rst=%b expected last=%0d",
                             load_done, core_rst, m_e.last);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        if (gap) begin
            byte_valid = 1'b0;
            byte_data  = ~b;
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        checks++;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk); #1;
                byte_valid = 1'b0;
                return;
            end
        end
        failures++;
        $display("FAIL send_byte_timeout got byte_ready=0 expected 1 within 16 cycles");
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load_program(input bit gap);
        for (int k = 0; k < prog.size(); k++)
            sb.push_back('{addr: WIDTH'(4 * k), data: prog[k], last: (k == prog.size() - 1)});
        send_word(32'(prog.size()), gap);
        for (int k = 0; k < prog.size(); k++) send_word(prog[k], gap);
    endtask

    task automatic drain(input string name);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain got %0d pending writes expected 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic check_status(input string name, input logic [3:0] exp);
        @(negedge clk);
        checks++;
        if ({byte_ready, core_rst, load_done, load_err} !== exp) begin
            failures++;
            $display("FAIL %s got ready/core_rst/done/err=%b expected %b", name,
                     {byte_ready, core_rst, load_done, load_err}, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({byte_ready, inst_store, core_rst, load_done, load_err} !== 5'b00100 ||
            inst_addr !== '0 || inst_in !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b store=%b core_rst=%b done=%b err=%b addr=%h data=%h expected 0,0,1,0,0,0,0",
                     byte_ready, inst_store, core_rst, load_done, load_err, inst_addr, inst_in);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        for (int i = 0; i < 4; i++) check_status("idle_ignores_bytes", 4'b0100);
        byte_valid = 1'b0;
        drain("idle");
    endtask

    task automatic test_nominal();
        do_start();
        check_status("nominal_hdr", 4'b1100);
        prog = {32'h00000013, 32'h00100093};
        load_program(1'b0);
        drain("nominal");
        checks++;
        if (inst_addr !== 32'd4 || inst_in !== 32'h00100093) begin
            failures++;
            $display("FAIL nominal_hold got addr=%h data=%h expected addr=00000004 data=00100093", inst_addr, inst_in);
        end
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        for (int i = 0; i < 3; i++) check_status("done_ignores_bytes", 4'b0010);
        byte_valid = 1'b0;
        drain("done_idle");
    endtask

    task automatic test_throttled();
        do_start();
        prog = {32'h00000013, 32'h00100093};
        load_program(1'b1);
        drain("throttled");
        check_status("throttled_done", 4'b0010);
    endtask

    task automatic test_bad_header();
        do_start();
        send_word(32'd0, 1'b0);
        check_status("hdr_zero_err", 4'b0101);
        byte_valid = 1'b1;
        byte_data  = 8'h01;
        check_status("err_ignores_bytes", 4'b0101);
        byte_valid = 1'b0;
        do_start();
        check_status("err_restart_clears", 4'b1100);
        send_word(32'(DEPTH + 1), 1'b0);
        check_status("hdr_over_depth_err", 4'b0101);
        drain("bad_header");
    endtask

    task automatic test_boundary();
        do_start();
        prog.delete();
        for (int k = 0; k < DEPTH; k++) prog.push_back($urandom);
        load_program(1'b0);
        drain("boundary");
        checks++;
        if (inst_addr !== WIDTH'(4 * (DEPTH - 1)) || load_done !== 1'b1) begin
            failures++;
            $display("FAIL boundary_last got addr=%h done=%b expected addr=%h done=1",
                     inst_addr, load_done, WIDTH'(4 * (DEPTH - 1)));
        end
    endtask

    task automatic test_mid_reset();
        do_start();
        send_word(32'd2, 1'b0);
        do_start();
        sb.push_back('{addr: '0, data: 32'hDEADBEEF, last: 1'b0});
        send_word(32'hDEADBEEF, 1'b0);
        send_byte(8'h11, 1'b0);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({byte_ready, inst_store, core_rst, load_done, load_err} !== 5'b00100 ||
            inst_addr !== '0 || inst_in !== '0) begin
            failures++;
            $display("FAIL async_reset got ready=%b store=%b core_rst=%b done=%b err=%b addr=%h data=%h expected 0,0,1,0,0,0,0",
                     byte_ready, inst_store, core_rst, load_done, load_err, inst_addr, inst_in);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        drain("after_reset");
        check_status("after_reset_idle", 4'b0100);
        do_start();
        prog = {32'hCAFEF00D};
        load_program(1'b0);
        drain("post_reset_load");
    endtask

    task automatic test_reload();
        do_start();
        check_status("reload_session", 4'b1100);
        prog = {32'h00000537};
        load_program(1'b0);
        drain("reload");
        check_status("reload_done", 4'b0010);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_throttled();
        test_bad_header();
        test_boundary();
        test_mid_reset();
        test_reload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
